// File: rtl/id_stage_hazard.sv
// Decode stage: opcode decode, register file with WB->ID bypass, immediate
// extension, load-use stall, branch flush and a registered ID/EX slot.
module id_stage_hazard #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  input  logic                  in_valid,
  input  logic [PC_WIDTH-1:0]   in_new_pc_value,
  input  logic                  in_RegWrite,
  input  logic [REG_ADDR_W-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  flush,
  output logic                  stall,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] extended_bits,
  output logic [PC_WIDTH-1:0]   new_pc_value,
  output logic [REG_ADDR_W-1:0] instr_bits_25_21,
  output logic [REG_ADDR_W-1:0] instr_bits_20_16,
  output logic [REG_ADDR_W-1:0] instr_bits_15_11,
  output logic                  RegDst,
  output logic                  RegWrite,
  output logic                  ALUSrc,
  output logic                  MemWrite,
  output logic                  MemRead,
  output logic                  MemToReg,
  output logic                  Branch,
  output logic [1:0]            load_mode,
  output logic [2:0]            ALUOp
);

  localparam int STAGES = 1;
  localparam logic [REG_ADDR_W:0] NREGS_W = (REG_ADDR_W+1)'(NUM_REGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] load_mode;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t                 ctrl;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] ext;
    logic [PC_WIDTH-1:0]   pc;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
  } idex_t;

  logic [5:0]            opcode;
  logic [15:0]           imm;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  ctrl_t                 ctrl_dec;
  logic                  zero_ext;
  logic [DATA_WIDTH-1:0] ext_val;

  assign opcode = instruction[31:26];
  assign imm    = instruction[15:0];
  assign rs     = REG_ADDR_W'(instruction[25:21]);
  assign rt     = REG_ADDR_W'(instruction[20:16]);
  assign rd     = REG_ADDR_W'(instruction[15:11]);

  always_comb begin
    ctrl_dec = '0;
    zero_ext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = 3'b010;
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.load_mode  = (opcode == OP_LH) ? 2'b01 :
                              (opcode == OP_LB) ? 2'b10 : 2'b00;
      end
      OP_SW: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = 3'b001;
      end
      OP_ADDI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = 3'b011;
        zero_ext           = 1'b1;
      end
      OP_ORI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = 3'b100;
        zero_ext           = 1'b1;
      end
      default: ctrl_dec = '0;
    endcase
  end

  assign ext_val = zero_ext ? {{(DATA_WIDTH-16){1'b0}}, imm}
                            : {{(DATA_WIDTH-16){imm[15]}}, imm};

  // Register file; entry 0 is never written so it always holds zero.
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic                                wr_ok;

  assign wr_ok = in_RegWrite && (write_register != '0) && ({1'b0, write_register} < NREGS_W);

  always_ff @(posedge clk) begin
    if (rst)        regs <= '0;
    else if (wr_ok) regs[write_register] <= write_data;
  end

  logic [1:0][REG_ADDR_W-1:0] rd_idx;
  logic [1:0][DATA_WIDTH-1:0] rd_val;

  assign rd_idx[0] = rs;
  assign rd_idx[1] = rt;

  // Same-cycle WB write is forwarded so the RF needs no half-cycle write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      if (rd_idx[p] != '0 && ({1'b0, rd_idx[p]} < NREGS_W)) begin
        if (in_RegWrite && write_register == rd_idx[p]) rd_val[p] = write_data;
        else                                            rd_val[p] = regs[rd_idx[p]];
      end
    end
  end

  idex_t q, d;
  logic  vld_pipe [STAGES:0];
  logic  stall_int;

  assign stall_int = vld_pipe[STAGES] & q.ctrl.mem_read & in_valid & (q.rt != '0) &
                     ((q.rt == rs) | (q.rt == rt));
  assign stall     = stall_int;

  always_comb begin
    d      = '0;
    d.ctrl = in_valid ? ctrl_dec : '0;
    d.rd1  = rd_val[0];
    d.rd2  = rd_val[1];
    d.ext  = ext_val;
    d.pc   = in_new_pc_value;
    d.rs   = rs;
    d.rt   = rt;
    d.rd   = rd;
  end

  assign vld_pipe[0] = in_valid;

  // Flush beats stall; both insert an all-zero bubble into ID/EX.
  always_ff @(posedge clk) begin
    if (rst || flush || stall_int) begin
      vld_pipe[1] <= 1'b0;
      q           <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      q           <= d;
    end
  end

  assign out_valid        = vld_pipe[STAGES];
  assign read_data1       = q.rd1;
  assign read_data2       = q.rd2;
  assign extended_bits    = q.ext;
  assign new_pc_value     = q.pc;
  assign instr_bits_25_21 = q.rs;
  assign instr_bits_20_16 = q.rt;
  assign instr_bits_15_11 = q.rd;
  assign RegDst           = q.ctrl.reg_dst;
  assign RegWrite         = q.ctrl.reg_write;
  assign ALUSrc           = q.ctrl.alu_src;
  assign MemWrite         = q.ctrl.mem_write;
  assign MemRead          = q.ctrl.mem_read;
  assign MemToReg         = q.ctrl.mem_to_reg;
  assign Branch           = q.ctrl.branch;
  assign load_mode        = q.ctrl.load_mode;
  assign ALUOp            = q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Vector-table bench for id_stage_hazard with an expected-result queue.
module tb_id_stage_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        in_valid;
  logic [31:0] in_new_pc_value;
  logic        in_RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        flush;
  logic        stall, out_valid;
  logic [31:0] read_data1, read_data2, extended_bits, new_pc_value;
  logic [4:0]  instr_bits_25_21, instr_bits_20_16, instr_bits_15_11;
  logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
  logic [1:0]  load_mode;
  logic [2:0]  ALUOp;

  id_stage_hazard dut (
    .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid),
    .in_new_pc_value(in_new_pc_value), .in_RegWrite(in_RegWrite),
    .write_register(write_register), .write_data(write_data), .flush(flush),
    .stall(stall), .out_valid(out_valid), .read_data1(read_data1),
    .read_data2(read_data2), .extended_bits(extended_bits),
    .new_pc_value(new_pc_value), .instr_bits_25_21(instr_bits_25_21),
    .instr_bits_20_16(instr_bits_20_16), .instr_bits_15_11(instr_bits_15_11),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemToReg(MemToReg), .Branch(Branch),
    .load_mode(load_mode), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  // {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch,load_mode,ALUOp}
  localparam logic [11:0] C_NONE = 12'b0_0_0_0_0_0_0_00_000;
  localparam logic [11:0] C_R    = 12'b1_1_0_0_0_0_0_00_010;
  localparam logic [11:0] C_LW   = 12'b0_1_1_0_1_1_0_00_000;
  localparam logic [11:0] C_LH   = 12'b0_1_1_0_1_1_0_01_000;
  localparam logic [11:0] C_LB   = 12'b0_1_1_0_1_1_0_10_000;
  localparam logic [11:0] C_SW   = 12'b0_0_1_1_0_0_0_00_000;
  localparam logic [11:0] C_ADDI = 12'b0_1_1_0_0_0_0_00_000;
  localparam logic [11:0] C_ANDI = 12'b0_1_1_0_0_0_0_00_011;
  localparam logic [11:0] C_ORI  = 12'b0_1_1_0_0_0_0_00_100;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        vld;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic [11:0] e_ctrl;
    logic [31:0] e_rd1, e_rd2, e_ext;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic [11:0] ctrl;
    logic [31:0] rd1, rd2, ext, pc;
    logic [4:0]  rt, rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[20];

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  function automatic vec_t v(input logic r, input logic [31:0] ins, input logic vl,
                             input logic we, input int wr, input logic [31:0] wd,
                             input logic fl, input logic es, input logic ev,
                             input logic [11:0] ec, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] ee);
    vec_t t;
    t.rst = r; t.instr = ins; t.vld = vl; t.we = we; t.wr = wr[4:0]; t.wd = wd;
    t.flush = fl; t.e_stall = es; t.e_valid = ev; t.e_ctrl = ec;
    t.e_rd1 = e1; t.e_rd2 = e2; t.e_ext = ee;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_now();
    return {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, load_mode, ALUOp};
  endfunction

  task automatic apply(input int i, input vec_t t, input logic [31:0] pc);
    exp_t e;
    logic bub;
    @(negedge clk);
    rst = t.rst; instruction = t.instr; in_valid = t.vld; in_new_pc_value = pc;
    in_RegWrite = t.we; write_register = t.wr; write_data = t.wd; flush = t.flush;
    #1;
    chk($sformatf("v%0d stall", i), 64'(stall), 64'(t.e_stall));
    bub     = t.rst | t.flush | t.e_stall;
    e.valid = t.e_valid;
    e.ctrl  = t.e_ctrl;
    e.rd1   = t.e_rd1;
    e.rd2   = t.e_rd2;
    e.ext   = t.e_ext;
    e.pc    = bub ? 32'd0 : pc;
    e.rt    = bub ? 5'd0 : t.instr[20:16];
    e.rd    = bub ? 5'd0 : t.instr[15:11];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(e.valid));
    chk($sformatf("v%0d ctrl", i), 64'(ctrl_now()), 64'(e.ctrl));
    chk($sformatf("v%0d read_data1", i), 64'(read_data1), 64'(e.rd1));
    chk($sformatf("v%0d read_data2", i), 64'(read_data2), 64'(e.rd2));
    chk($sformatf("v%0d extended_bits", i), 64'(extended_bits), 64'(e.ext));
    chk($sformatf("v%0d new_pc_value", i), 64'(new_pc_value), 64'(e.pc));
    chk($sformatf("v%0d rt", i), 64'(instr_bits_20_16), 64'(e.rt));
    chk($sformatf("v%0d rd", i), 64'(instr_bits_15_11), 64'(e.rd));
  endtask

  initial begin
    rst = 1'b1; instruction = '0; in_valid = 1'b0; in_new_pc_value = '0;
    in_RegWrite = 1'b1; write_register = 5'd5; write_data = 32'hAAAA_AAAA; flush = 1'b0;

    //           rst instr                          vld we wr wd            fl st  ev ctrl    rd1           rd2           ext
    vecs[0]  = v(0, r_ins(8, 0, 1),                 1, 1, 8, 32'hDEADBEEF, 0, 0, 1, C_R,    32'hDEADBEEF, 0,            32'h0820);
    vecs[1]  = v(0, r_ins(5, 0, 2),                 1, 1, 0, 32'h1234,     0, 0, 1, C_R,    0,            0,            32'h1020);
    vecs[2]  = v(0, i_ins(6'h08, 0, 9, 16'h8000),   1, 0, 0, 0,            0, 0, 1, C_ADDI, 0,            0,            32'hFFFF8000);
    vecs[3]  = v(0, i_ins(6'h0D, 8, 10, 16'h8000),  1, 0, 0, 0,            0, 0, 1, C_ORI,  32'hDEADBEEF, 0,            32'h00008000);
    vecs[4]  = v(0, i_ins(6'h0C, 8, 11, 16'hFFFF),  1, 1, 2, 32'h55,       0, 0, 1, C_ANDI, 32'hDEADBEEF, 0,            32'h0000FFFF);
    vecs[5]  = v(0, i_ins(6'h23, 2, 3, 16'h0004),   1, 0, 0, 0,            0, 0, 1, C_LW,   32'h55,       0,            32'h4);
    vecs[6]  = v(0, r_ins(3, 1, 4),                 1, 0, 0, 0,            0, 1, 0, C_NONE, 0,            0,            0);
    vecs[7]  = v(0, r_ins(3, 1, 4),                 1, 1, 3, 32'h77,       0, 0, 1, C_R,    32'h77,       0,            32'h2020);
    vecs[8]  = v(0, i_ins(6'h23, 0, 6, 16'h0000),   1, 0, 0, 0,            0, 0, 1, C_LW,   0,            0,            0);
    vecs[9]  = v(0, i_ins(6'h2B, 7, 6, 16'h0000),   1, 0, 0, 0,            1, 1, 0, C_NONE, 0,            0,            0);
    vecs[10] = v(0, i_ins(6'h21, 0, 12, 16'h0002),  1, 0, 0, 0,            0, 0, 1, C_LH,   0,            0,            32'h2);
    vecs[11] = v(0, i_ins(6'h20, 0, 13, 16'hFFFF),  1, 0, 0, 0,            0, 0, 1, C_LB,   0,            0,            32'hFFFFFFFF);
    vecs[12] = v(0, i_ins(6'h2B, 0, 14, 16'h0008),  1, 0, 0, 0,            0, 0, 1, C_SW,   0,            0,            32'h8);
    vecs[13] = v(0, r_ins(8, 8, 15),                0, 0, 0, 0,            0, 0, 0, C_NONE, 32'hDEADBEEF, 32'hDEADBEEF, 32'h7820);
    vecs[14] = v(0, i_ins(6'h3F, 0, 0, 16'h1234),   1, 0, 0, 0,            0, 0, 1, C_NONE, 0,            0,            32'h1234);
    vecs[15] = v(0, i_ins(6'h23, 0, 3, 16'h0000),   1, 0, 0, 0,            0, 0, 1, C_LW,   0,            32'h77,       0);
    vecs[16] = v(0, r_ins(3, 3, 5),                 0, 0, 0, 0,            0, 0, 0, C_NONE, 32'h77,       32'h77,       32'h2820);
    vecs[17] = v(0, i_ins(6'h23, 0, 3, 16'h0000),   1, 0, 0, 0,            0, 0, 1, C_LW,   0,            32'h77,       0);
    vecs[18] = v(1, r_ins(3, 3, 5),                 1, 0, 0, 0,            0, 1, 0, C_NONE, 0,            0,            0);
    vecs[19] = v(0, r_ins(3, 3, 5),                 1, 0, 0, 0,            0, 0, 1, C_R,    0,            0,            32'h2820);

    // Reset held two cycles while WB tries to write r5.
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset ctrl", 64'(ctrl_now()), 64'd0);
    chk("reset read_data1", 64'(read_data1), 64'd0);
    chk("reset read_data2", 64'(read_data2), 64'd0);
    chk("reset extended_bits", 64'(extended_bits), 64'd0);
    chk("reset new_pc_value", 64'(new_pc_value), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);

    for (int i = 0; i < 20; i++) apply(i, vecs[i], 32'h1000 + 32'(i * 4));

    // After the mid-stall reset, the held add issues with no further stall.
    @(negedge clk);
    in_valid = 1'b1; instruction = r_ins(1, 2, 6);
    #1;
    chk("post-reset stall", 64'(stall), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
